// File: rtl/adc_pkg.sv
// Shared state type and frame-timing helpers for the serial ADC sample reader.
package adc_pkg;

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} adc_state_e;

  localparam int unsigned ADC_WIDTH     = 10;
  localparam int unsigned ADC_LEAD_BITS = 3;
  localparam int unsigned FRAME_BITS    = ADC_LEAD_BITS + ADC_WIDTH;

  function automatic int unsigned frame_bits(input int unsigned lead_bits,
                                             input int unsigned width);
    return lead_bits + width;
  endfunction

  // Cycles from the accepted tick to the sample_valid strobe.
  function automatic int unsigned frame_latency(input int unsigned sclk_div,
                                                input int unsigned lead_bits,
                                                input int unsigned width);
    return sclk_div * (2 + 2 * frame_bits(lead_bits, width)) + 1;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running 0..TICK_DIV-1 counter with a one-cycle tick on the terminal count.
module sample_tick_gen #(
  parameter int unsigned TICK_DIV = 20000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntLast);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_sample_reader.sv
// Clocks one frame out of a serial ADC per sample tick and presents a signed sample.
// Define ADC_OFFSET_BINARY_EN when the ADC delivers offset-binary words.
module adc_sample_reader
  import adc_pkg::*;
#(
  parameter int unsigned Width     = 10,
  parameter int unsigned CLK_HZ    = 1_000_000,
  parameter int unsigned FS_HZ     = 50,
  parameter int unsigned SCLK_DIV  = 4,
  parameter int unsigned LEAD_BITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  output logic                    adc_cs_n,
  output logic                    adc_sclk,
  input  logic                    adc_miso,
  output logic signed [Width-1:0] sample_out,
  output logic                    sample_valid,
  output logic                    overrun
);

  localparam int unsigned TICK_DIV  = CLK_HZ / FS_HZ;
  localparam int unsigned FrameBits = frame_bits(LEAD_BITS, Width);
  localparam int unsigned CntW      = (2 * SCLK_DIV > 1) ? $clog2(2 * SCLK_DIV) : 1;
  localparam int unsigned BitW      = (FrameBits > 1) ? $clog2(FrameBits) : 1;

  localparam logic [CntW-1:0] HalfDiv    = CntW'(SCLK_DIV);
  localparam logic [CntW-1:0] HalfLast   = CntW'(SCLK_DIV - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(2 * SCLK_DIV - 1);
  localparam logic [BitW-1:0] BitLast    = BitW'(FrameBits - 1);

  adc_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [Width-1:0] shreg_q, shreg_d;
  logic [Width-1:0] sample_q, sample_d;
  logic [Width-1:0] word;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             valid_q, valid_d;
  logic             tick;

  sample_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

`ifdef ADC_OFFSET_BINARY_EN
  assign word = {~shreg_q[Width-1], shreg_q[Width-2:0]};
`else
  assign word = shreg_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StSetup;
          cnt_d   = '0;
        end
      end
      StSetup: begin
        if (cnt_q == HalfLast) begin
          state_d = StShift;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StShift: begin
        if (cnt_q == PeriodLast) begin
          cnt_d = '0;
          if (bit_q == BitLast) begin
            state_d = StHold;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == HalfLast) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin outputs are registered from the next state so they change cleanly on the clock edge.
  always_comb begin
    sclk_d   = (state_d == StShift) && (cnt_d >= HalfDiv);
    cs_n_d   = !((state_d == StSetup) || (state_d == StShift) || (state_d == StHold));
    valid_d  = (state_d == StDone);
    shreg_d  = shreg_q;
    sample_d = sample_q;
    // Lead bits are shifted in too but fall off the top before the word completes.
    if (sclk_d && !sclk_q) begin
      shreg_d = {shreg_q[Width-2:0], adc_miso};
    end
    if ((state_q == StHold) && (state_d == StDone)) begin
      sample_d = word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      sample_q <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      sample_q <= sample_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      valid_q  <= valid_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = tick && (state_q != StIdle);

endmodule

// File: tb/tb_adc_sample_reader.sv
// Directed bench for adc_sample_reader with a behavioural serial ADC model.
module tb_adc_sample_reader;
  import adc_pkg::*;

  localparam int unsigned W    = 10;
  localparam int unsigned LEAD = 3;

`ifdef ADC_OFFSET_BINARY_EN
  localparam logic [W-1:0] EXP_3FF = 10'h1FF;
  localparam logic [W-1:0] EXP_000 = 10'h200;
  localparam logic [W-1:0] EXP_200 = 10'h000;
  localparam logic [W-1:0] EXP_2A5 = 10'h0A5;
`else
  localparam logic [W-1:0] EXP_3FF = 10'h3FF;
  localparam logic [W-1:0] EXP_000 = 10'h000;
  localparam logic [W-1:0] EXP_200 = 10'h200;
  localparam logic [W-1:0] EXP_2A5 = 10'h2A5;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         miso = 1'b0;
  logic         adc_cs_n, adc_sclk, sample_valid, overrun;
  logic [W-1:0] sample_out;

  logic         ov_rst_n = 1'b0;
  logic         ov_miso = 1'b1;
  logic         ov_cs_n, ov_sclk, ov_valid, ov_overrun;
  logic [W-1:0] ov_sample;

  int           cyc = 0;
  int           base = 0;
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] raw_word = '0;
  logic         lead_val = 1'b0;
  int           bit_k = 0;
  int           cs_low_cnt = 0, rise_cnt = 0, last_cs_low = 0, last_rises = 0;
  int           main_ovr_cnt = 0;
  logic         sclk_prev = 1'b0;

  adc_sample_reader #(
    .Width(W), .CLK_HZ(10000), .FS_HZ(50), .SCLK_DIV(2), .LEAD_BITS(LEAD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_miso(miso),
    .sample_out(sample_out), .sample_valid(sample_valid), .overrun(overrun)
  );

  // TICK_DIV = 40, shorter than the 57-cycle frame.
  adc_sample_reader #(
    .Width(W), .CLK_HZ(2000), .FS_HZ(50), .SCLK_DIV(2), .LEAD_BITS(LEAD)
  ) dut_ov (
    .clk(clk), .rst_n(ov_rst_n), .adc_cs_n(ov_cs_n), .adc_sclk(ov_sclk), .adc_miso(ov_miso),
    .sample_out(ov_sample), .sample_valid(ov_valid), .overrun(ov_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [W-1:0] conv(input logic [W-1:0] raw);
`ifdef ADC_OFFSET_BINARY_EN
    return raw ^ 10'h200;
`else
    return raw;
`endif
  endfunction

  function automatic logic adc_bit(input int k);
    if (k < int'(LEAD)) return lead_val;
    if (k - int'(LEAD) < int'(W)) return raw_word[W-1-(k-int'(LEAD))];
    return 1'b0;
  endfunction

  // ADC shifts its next bit out after each SCLK rise; bit 0 is presented at CS fall.
  always @(negedge adc_cs_n or posedge adc_sclk) begin
    if (adc_sclk) begin
      #1;
      bit_k = bit_k + 1;
    end else begin
      bit_k = 0;
    end
    miso = adc_bit(bit_k);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      cs_low_cnt = 0;
      rise_cnt   = 0;
      sclk_prev  = 1'b0;
    end else begin
      if (!adc_cs_n) cs_low_cnt++;
      if (adc_sclk && !sclk_prev) rise_cnt++;
      sclk_prev = adc_sclk;
      if (overrun) main_ovr_cnt++;
      if (sample_valid) begin
        last_cs_low = cs_low_cnt;
        last_rises  = rise_cnt;
        cs_low_cnt  = 0;
        rise_cnt    = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int rel_at);
    rel_at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        rel_at = cyc - base;
        break;
      end
    end
    if (rel_at < 0) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int rel, prev, r, ov_cnt, v_cnt, ov_base;
    logic exp_o, exp_v;

    raw_word = 10'h3FF;
    lead_val = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(adc_cs_n), 32'd1);
    check("rst_sclk", 32'(adc_sclk), 32'd0);
    check("rst_sample", 32'(sample_out), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("latency_fn", frame_latency(2, 3, 10), 32'd57);

    rst_n = 1'b1;
    base  = cyc;
    // First tick at rel 199, valid 57 cycles later.
    wait_valid(400, rel);
    check("first_valid_rel", 32'(rel), 32'd256);
    check("sample_3ff", 32'(sample_out), 32'(EXP_3FF));
    raw_word = 10'h000;
    @(negedge clk);
    check("valid_one_cycle", 32'(sample_valid), 32'd0);
    check("sample_held", 32'(sample_out), 32'(EXP_3FF));
    check("cs_low_cycles", 32'(last_cs_low), 32'd56);
    check("sclk_rises", 32'(last_rises), 32'd13);

    wait_valid(400, rel);
    check("valid_rel_000", 32'(rel), 32'd456);
    check("sample_000", 32'(sample_out), 32'(EXP_000));
    raw_word = 10'h200;
    wait_valid(400, rel);
    check("valid_rel_200", 32'(rel), 32'd656);
    check("sample_200", 32'(sample_out), 32'(EXP_200));
    raw_word = 10'h2A5;
    lead_val = 1'b1;
    wait_valid(400, rel);
    check("valid_rel_2a5", 32'(rel), 32'd856);
    check("sample_2a5_lead1", 32'(sample_out), 32'(EXP_2A5));

    prev = rel;
    for (int i = 0; i < 100; i++) begin
      raw_word = W'($urandom);
      lead_val = 1'($urandom);
      wait_valid(400, rel);
      check("rand_spacing", 32'(rel - prev), 32'd200);
      check("rand_sample", 32'(sample_out), 32'(conv(raw_word)));
      prev = rel;
    end

    // Reset in the middle of a frame.
    raw_word = 10'h155;
    lead_val = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!adc_cs_n) break;
    end
    check("cs_fall_seen", 32'(adc_cs_n), 32'd0);
    repeat (29) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_cs_n", 32'(adc_cs_n), 32'd1);
    check("midrst_sclk", 32'(adc_sclk), 32'd0);
    check("midrst_sample", 32'(sample_out), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base  = cyc;
    wait_valid(400, rel);
    check("postrst_valid_rel", 32'(rel), 32'd256);
    check("postrst_sample", 32'(sample_out), 32'(conv(10'h155)));

    // Overrun instance: ticks at 39 + 40n; frames accepted every other tick.
    ov_cnt  = 0;
    v_cnt   = 0;
    @(negedge clk);
    ov_rst_n = 1'b1;
    ov_base  = cyc;
    for (int i = 0; i < 420; i++) begin
      @(negedge clk);
      r     = cyc - ov_base;
      exp_o = (r >= 79) && ((r - 79) % 80 == 0);
      exp_v = (r >= 96) && ((r - 96) % 80 == 0);
      if (ov_overrun || exp_o) check("ov_overrun", 32'(ov_overrun), 32'(exp_o));
      if (ov_valid || exp_v) check("ov_valid", 32'(ov_valid), 32'(exp_v));
      if (ov_valid) check("ov_sample", 32'(ov_sample), 32'(conv(10'h3FF)));
      if (ov_overrun) ov_cnt++;
      if (ov_valid) v_cnt++;
    end
    check("ov_overrun_count", 32'(ov_cnt), 32'd5);
    check("ov_valid_count", 32'(v_cnt), 32'd5);
    check("main_no_overrun", 32'(main_ovr_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_sample_reader.md
# adc_sample_reader

Serial ADC front-end that produces the fixed-rate signed sample stream consumed by the pre-processing filter chain (LPF `en`/`x_in`). It generates the sample-rate tick, clocks one conversion frame out of an external 10-bit SPI-style ADC, converts the result to two's complement, and presents it with a one-cycle valid strobe. It sits between the ADC pins and the first filter stage in the BPM digital block.

## Interface
Parameters:
- `Width`, 10, sample width in bits, ADC resolution and output width.
- `CLK_HZ`, 1_000_000, system clock frequency.
- `FS_HZ`, 50, output sample rate; `TICK_DIV = CLK_HZ/FS_HZ` (integer, ≥ frame length).
- `SCLK_DIV`, 4, clk cycles per SCLK half-period (≥1).
- `LEAD_BITS`, 3, don't-care SCLK cycles before the MSB (sample/hold + null bit).

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `adc_cs_n`  out  1  ADC chip select, active low.
- `adc_sclk`  out  1  ADC serial clock, idles low.
- `adc_miso`  in  1  ADC serial data, MSB first, valid at SCLK rise.
- `sample_out`  out  Width  signed sample, held between strobes.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates; wired to the LPF `en`.
- `overrun`  out  1  one-cycle pulse when a tick arrives while a frame is in progress.

## Operation
- Reset values: `adc_cs_n`=1, `adc_sclk`=0, `sample_out`=0, `sample_valid`=0, `overrun`=0, tick counter=0, FSM=IDLE.
- Tick: free-running counter 0..TICK_DIV-1; one-cycle tick when the counter equals TICK_DIV-1. First tick after TICK_DIV cycles out of reset.
- FSM states:
  - IDLE: cs_n=1, sclk=0. On tick → SETUP.
  - SETUP: cs_n=0, sclk=0 for SCLK_DIV cycles → SHIFT.
  - SHIFT: `LEAD_BITS+Width` SCLK periods, each low SCLK_DIV cycles then high SCLK_DIV cycles. `adc_miso` is captured on the edge where sclk goes 0→1. Lead bits are discarded; the next Width bits shift in MSB first. After the final high phase → HOLD.
  - HOLD: cs_n=0, sclk=0 for SCLK_DIV cycles → DONE.
  - DONE: one cycle; cs_n=1; `sample_out` loaded with the converted word; `sample_valid`=1 → IDLE.
- Tick while not IDLE: the tick is dropped, the frame continues, and `overrun` pulses in the same cycle as the tick.
- Tick coincident with DONE: counts as overrun. No back-to-back frame starts.
- Reset asserted mid-frame: all outputs return immediately to reset values and the partial word is discarded.
- `sample_out` is updated only in DONE.

## Timing
- Frame length from tick to `sample_valid`: `SCLK_DIV*(2 + 2*(LEAD_BITS+Width)) + 1` cycles. With defaults this is 4·28+1 = 113.
- `adc_cs_n` falls on the cycle after the tick and rises on the `sample_valid` cycle.
- `sample_valid` is high for exactly 1 cycle per accepted tick.
- The sample period is exactly TICK_DIV cycles, regardless of overruns.

## Configuration
- `ADC_OFFSET_BINARY_EN` defined: the ADC word is offset binary, so `sample_out = {~raw[Width-1], raw[Width-2:0]}`. For example, raw 10'h200 → 0 and raw 10'h000 → −512.
- Not defined: the raw word is already two's complement and passes unchanged.

## Structure
- Package `adc_pkg`:
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, DONE).
  - `FRAME_BITS = LEAD_BITS+Width` helper constant.
  - Function computing the frame latency, for the bench.
- Sub-module `sample_tick_gen`: parameterised TICK_DIV counter with a one-cycle `tick` output. It is reusable for other rate strobes in the BPM block.

## Test plan
Test parameters: CLK_HZ=10000, FS_HZ=50 (TICK_DIV=200), SCLK_DIV=2, LEAD_BITS=3.
- ADC model drives raw 10'h3FF, macro on → `sample_valid` at tick+57 cycles with `sample_out`=+511; 13 SCLK rising edges per frame; cs_n low for 56 cycles.
- Macro on, raw 10'h000 then 10'h200 → `sample_out` −512, then 0, on consecutive strobes 200 cycles apart.
- Macro off, raw 10'h2A5 → `sample_out`=10'h2A5 (−347); lead-bit miso forced to 1 does not affect the result.
- TICK_DIV forced to 40 (< 57-cycle frame) → `overrun` pulses on every tick that lands inside a frame; a valid strobe still follows each accepted frame and no frame restarts early.
- `rst_n` pulsed low at frame cycle 30 → cs_n=1 and sclk=0 in the same cycle; no `sample_valid` for that frame; `sample_out`=0; next valid frame after a fresh 200-cycle tick.
- 100 frames of random raw words → each `sample_valid` matches the model word and strobes are spaced exactly 200 cycles apart.
